// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game tick, menu/play/won/lost FSM, jump height and obstacle scroll for the video stage
module game_state_ctrl #(
  parameter int TICK_DIV    = 416667,
  parameter int SCROLL_STEP = 2,
  parameter int OBJ_WRAP    = 640,
  parameter int JUMP_STEP   = 4,
  parameter int JUMP_HEIGHT = 80,
  parameter int WIN_LAPS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       jump_btn,
  input  logic       hit,
  output logic       game_clk,
  output logic       menuScreen,
  output logic       playerWon,
  output logic       playerLost,
  output logic [9:0] distance,
  output logic [9:0] obj_counter,
  output logic [3:0] laps
);
  typedef enum logic [1:0] {MENU, PLAY, WON, LOST} state_t;
  typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;
  localparam int DW = $clog2(TICK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic          tick_q;
  logic [2:0]    st_sync_q, jp_sync_q;
  state_t        state_q, state_d;
  jump_t         jump_q, jump_d;
  logic [9:0]    dist_q, dist_d, obj_q, obj_d;
  logic [3:0]    laps_q, laps_d;
  logic          start_p, jump_p, div_end;
  logic [10:0]   obj_sum, dist_up;
  assign div_end = div_q == DW'(TICK_DIV - 1);
  assign div_d   = div_end ? '0 : div_q + DW'(1);
  // two synchroniser flops then a delay flop; pulse on the rising edge of the synchronised level
  assign start_p = st_sync_q[1] & ~st_sync_q[2];
  assign jump_p  = jp_sync_q[1] & ~jp_sync_q[2];
  assign obj_sum = {1'b0, obj_q} + 11'(SCROLL_STEP);
  assign dist_up = {1'b0, dist_q} + 11'(JUMP_STEP);
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q     <= '0;
      tick_q    <= 1'b0;
      st_sync_q <= '0;
      jp_sync_q <= '0;
      state_q   <= MENU;
      jump_q    <= GROUND;
      dist_q    <= '0;
      obj_q     <= '0;
      laps_q    <= '0;
    end else begin
      div_q     <= div_d;
      tick_q    <= div_end;
      st_sync_q <= {st_sync_q[1:0], start_btn};
      jp_sync_q <= {jp_sync_q[1:0], jump_btn};
      state_q   <= state_d;
      jump_q    <= jump_d;
      dist_q    <= dist_d;
      obj_q     <= obj_d;
      laps_q    <= laps_d;
    end
  end
  always_comb begin
    state_d = state_q;
    jump_d  = jump_q;
    dist_d  = dist_q;
    obj_d   = obj_q;
    laps_d  = laps_q;
    case (state_q)
      MENU: if (start_p) begin
        state_d = PLAY;
        jump_d  = GROUND;
        dist_d  = '0;
        obj_d   = '0;
        laps_d  = '0;
      end
      PLAY: if (hit) state_d = LOST;
      else begin
        if (tick_q) begin
          if (obj_sum >= 11'(OBJ_WRAP)) begin
            obj_d   = '0;
            laps_d  = laps_q + 4'd1;
            state_d = (laps_q + 4'd1 == 4'(WIN_LAPS)) ? WON : PLAY;
          end else obj_d = obj_sum[9:0];
        end
        case (jump_q)
          GROUND: jump_d = jump_p ? RISE : GROUND;
          RISE: if (tick_q) begin
            jump_d = (dist_up >= 11'(JUMP_HEIGHT)) ? FALL : RISE;
            dist_d = (dist_up >= 11'(JUMP_HEIGHT)) ? 10'(JUMP_HEIGHT) : dist_up[9:0];
          end
          FALL: if (tick_q) begin
            jump_d = ({1'b0, dist_q} <= 11'(JUMP_STEP)) ? GROUND : FALL;
            dist_d = ({1'b0, dist_q} <= 11'(JUMP_STEP)) ? '0 : dist_q - 10'(JUMP_STEP);
          end
          default: jump_d = GROUND;
        endcase
      end
      default: state_d = start_p ? MENU : state_q;
    endcase
  end
  always_comb begin
    game_clk    = tick_q;
    menuScreen  = state_q == MENU;
    playerWon   = state_q == WON;
    playerLost  = state_q == LOST;
    distance    = dist_q;
    obj_counter = obj_q;
    laps        = laps_q;
  end
endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Upstream game-logic stage that drives the video stage. It generates the game tick, runs the menu/play/won/lost state machine, and produces the player jump height (distance) and the obstacle scroll position (obj_counter). The pixel generator consumes these values, and its collision result is fed back here as hit.

Parameters:
TICK_DIV, 416667, clk cycles per game tick (50 MHz / 120 Hz); minimum 2
SCROLL_STEP, 2, obj_counter increment per tick
OBJ_WRAP, 640, obj_counter wrap limit (exclusive)
JUMP_STEP, 4, distance change per tick while airborne
JUMP_HEIGHT, 80, jump apex; must satisfy JUMP_HEIGHT <= 1023
WIN_LAPS, 5, completed scroll wraps needed to win; range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start_btn  in  1  raw start button, asynchronous
jump_btn  in  1  raw jump button, asynchronous
hit  in  1  collision flag from the video stage, synchronous to clk
game_clk  out  1  one-cycle game-tick pulse
menuScreen  out  1  high in MENU
playerWon  out  1  high in WON
playerLost  out  1  high in LOST
distance  out  10  player height above ground, in pixels
obj_counter  out  10  obstacle scroll position
laps  out  4  completed wraps in the current run

Behaviour:
- One clock and one reset. Reset is synchronous and active-low: reset==0 at a clk edge forces reset values. The port names are clk and reset.
- Reset values:
  - state=MENU, jump=GROUND
  - menuScreen=1; playerWon=0; playerLost=0; game_clk=0
  - distance=0; obj_counter=0; laps=0
  - tick divider=0; synchroniser flops=0
- Reset asserted mid-operation overrides every other event on that edge.
- Tick generation:
  - The divider counts 0..TICK_DIV-1 in every state.
  - game_clk is registered high for exactly the one cycle after the divider reaches TICK_DIV-1. The period is TICK_DIV cycles.
  - "On tick" means an edge at which game_clk==1.
- Buttons:
  - Each button passes through a 2-flop synchroniser plus a delay flop.
  - The press pulse is sync2 & ~sync3.
  - A button first sampled high at edge N acts at edge N+2.
  - Holding a button produces exactly one pulse.
- Top FSM (menuScreen, playerWon, playerLost are decoded directly from registered state):
  - MENU: on start pulse -> PLAY. On the same edge, distance, obj_counter, laps and jump are cleared. jump_btn is ignored.
  - PLAY, priority high to low:
    - (1) hit==1 -> LOST; no counter updates on that edge.
    - (2) On tick: if obj_counter+SCROLL_STEP >= OBJ_WRAP, obj_counter<=0 and laps<=laps+1. If the new laps equals WIN_LAPS, go to WON on the same edge. Otherwise obj_counter<=obj_counter+SCROLL_STEP.
    - start pulse is ignored.
  - WON / LOST:
    - distance, obj_counter and laps are frozen; hit and jump_btn are ignored.
    - start pulse -> MENU, holding frozen values until the next MENU->PLAY clear.
- Jump FSM (updates only in PLAY):
  - GROUND:
    - A jump pulse -> RISE on that edge; distance is unchanged.
    - A pulse while in RISE or FALL is ignored.
  - RISE, on tick:
    - If distance+JUMP_STEP >= JUMP_HEIGHT: distance<=JUMP_HEIGHT, -> FALL.
    - Else distance<=distance+JUMP_STEP.
  - FALL, on tick:
    - If distance <= JUMP_STEP: distance<=0, -> GROUND.
    - Else distance<=distance-JUMP_STEP.
  - Arithmetic is 11-bit internally. distance never exceeds JUMP_HEIGHT and never underflows.
- Simultaneous events:
  - A jump pulse on a tick edge in GROUND enters RISE; the first increment comes on the next tick.
  - A hit on the wrap/win edge gives LOST, not WON.
  - Leaving PLAY freezes the jump state and distance.

Test Plan:
1. TICK_DIV=4; hold reset=0 for 3 cycles, then release. -> menuScreen=1, all counters 0. game_clk pulses every 4 cycles, each pulse 1 cycle wide.
2. Start pressed, first sampled high at edge N. -> PLAY at edge N+2, menuScreen=0. After 10 ticks obj_counter=20. Holding start for 50 cycles produces no further transition.
3. JUMP_STEP=4, JUMP_HEIGHT=10; jump pulse in PLAY. -> distance over ticks: 4, 8, 10 (saturate, FALL), 6, 2, 0 (GROUND). A second jump pulse during RISE is ignored.
4. OBJ_WRAP=8, SCROLL_STEP=3, WIN_LAPS=2. -> obj_counter 3, 6, 0 (laps=1), 3, 6, 0 (laps=2). playerWon=1 on that edge, and obj_counter stays 0 on later ticks.
5. hit=1 in PLAY mid-jump (distance=8) on a tick edge. -> playerLost=1, distance stays 8, obj_counter unchanged. Start pulse -> MENU. Next start -> PLAY with distance=0, obj_counter=0, laps=0.
6. Win edge and hit=1 on the same edge. -> LOST. Also, reset=0 asserted during RISE -> all outputs return to reset values on that edge.
